// File: rtl/qpn_alloc_ctrl.sv
// rtl/qpn_alloc_ctrl.sv - local QP number allocator: pops free QPNs on open, validates and returns them on close
// Tracks a per-QP active bitmap; one open or close transaction is in flight at a time.
module qpn_alloc_ctrl #(
  parameter int MAX_QUEUE_PAIRS = 4,
  parameter int QPN_BASE        = 256
) (
  input  logic                               clk,
  input  logic                               rst_n,

  input  logic                               s_open_req_valid,
  output logic                               s_open_req_ready,
  input  logic [23:0]                        s_open_rem_qpn,

  output logic                               m_open_resp_valid,
  input  logic                               m_open_resp_ready,
  output logic [23:0]                        m_open_resp_qpn,
  output logic [23:0]                        m_open_resp_rem_qpn,

  input  logic                               s_close_req_valid,
  output logic                               s_close_req_ready,
  input  logic [23:0]                        s_close_qpn,

  output logic                               m_close_resp_valid,
  input  logic                               m_close_resp_ready,
  output logic                               m_close_resp_ok,
  output logic [23:0]                        m_close_resp_qpn,

  input  logic                               s_qpn_fifo_valid,
  output logic                               s_qpn_fifo_ready,
  input  logic [23:0]                        s_qpn,

  output logic                               m_qpn_fifo_valid,
  input  logic                               m_qpn_fifo_ready,
  output logic [23:0]                        m_qpn,

  output logic [MAX_QUEUE_PAIRS-1:0]         qp_active,
  output logic [$clog2(MAX_QUEUE_PAIRS):0]   active_count
);

  localparam int          CNT_W = $clog2(MAX_QUEUE_PAIRS) + 1;
  localparam logic [23:0] BASE  = 24'(QPN_BASE);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    OPEN_RESP   = 3'd1,
    CLOSE_CHECK = 3'd2,
    CLOSE_PUSH  = 3'd3,
    CLOSE_RESP  = 3'd4
  } state_t;

  state_t state;
  state_t next_state;

  logic [23:0]                close_qpn_q;
  logic [MAX_QUEUE_PAIRS-1:0] open_mask;
  logic [MAX_QUEUE_PAIRS-1:0] close_mask;
  logic                       open_new;
  logic                       close_hit;
  logic                       open_fire;
  logic                       close_fire;

  // One-hot decode by full 24-bit equality so out-of-range QPNs give an all-zero mask.
  always_comb begin
    open_mask  = '0;
    close_mask = '0;
    for (int i = 0; i < MAX_QUEUE_PAIRS; i++) begin
      open_mask[i]  = (s_qpn == BASE + 24'(i));
      close_mask[i] = (close_qpn_q == BASE + 24'(i));
    end
  end

  assign open_new   = (|open_mask) && ((open_mask & qp_active) == '0);
  assign close_hit  = |(close_mask & qp_active);
  assign open_fire  = s_open_req_valid && s_open_req_ready;
  assign close_fire = s_close_req_valid && s_close_req_ready;

  assign s_qpn_fifo_ready = open_fire;
  assign m_qpn            = close_qpn_q;
  assign m_close_resp_qpn = close_qpn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (s_close_req_valid) begin
          next_state = CLOSE_CHECK;
        end else if (s_open_req_valid && s_qpn_fifo_valid) begin
          next_state = OPEN_RESP;
        end
      end
      OPEN_RESP: begin
        if (m_open_resp_ready) begin
          next_state = IDLE;
        end
      end
      CLOSE_CHECK: begin
        next_state = close_hit ? CLOSE_PUSH : CLOSE_RESP;
      end
      CLOSE_PUSH: begin
        if (m_qpn_fifo_ready) begin
          next_state = CLOSE_RESP;
        end
      end
      CLOSE_RESP: begin
        if (m_close_resp_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Readies are gated by rst_n so they fall the moment reset asserts, not at the next edge.
  always_comb begin
    s_close_req_ready  = 1'b0;
    s_open_req_ready   = 1'b0;
    m_open_resp_valid  = 1'b0;
    m_qpn_fifo_valid   = 1'b0;
    m_close_resp_valid = 1'b0;
    case (state)
      IDLE: begin
        s_close_req_ready = rst_n;
        s_open_req_ready  = rst_n && s_qpn_fifo_valid && !s_close_req_valid;
      end
      OPEN_RESP:  m_open_resp_valid  = 1'b1;
      CLOSE_PUSH: m_qpn_fifo_valid   = 1'b1;
      CLOSE_RESP: m_close_resp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      close_qpn_q         <= '0;
      m_open_resp_qpn     <= '0;
      m_open_resp_rem_qpn <= '0;
      m_close_resp_ok     <= 1'b0;
      qp_active           <= '0;
      active_count        <= '0;
    end else begin
      if (close_fire) begin
        close_qpn_q <= s_close_qpn;
      end
      // A popped QPN that is out of range or already active is echoed but never counted twice.
      if (open_fire) begin
        m_open_resp_qpn     <= s_qpn;
        m_open_resp_rem_qpn <= s_open_rem_qpn;
        if (open_new) begin
          qp_active    <= qp_active | open_mask;
          active_count <= active_count + CNT_W'(1);
        end
      end
      if (state == CLOSE_CHECK) begin
        if (close_hit) begin
          qp_active    <= qp_active & ~close_mask;
          active_count <= active_count - CNT_W'(1);
        end else begin
          m_close_resp_ok <= 1'b0;
        end
      end
      if (state == CLOSE_PUSH && m_qpn_fifo_ready) begin
        m_close_resp_ok <= 1'b1;
      end
    end
  end

endmodule

// File: doc/qpn_alloc_ctrl.md
QPN_ALLOC_CTRL -- requirements
Module: qpn_alloc_ctrl

Interface
REQ-001 SHALL have parameter MAX_QUEUE_PAIRS, default 4, meaning number of local QPs (power of two, >=2).
REQ-002 SHALL have parameter QPN_BASE, default 256, meaning first local QPN; the valid local range is QPN_BASE..QPN_BASE+MAX_QUEUE_PAIRS-1.
REQ-003 SHALL have port clk  input  1  the single clock; all state is on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports s_open_req_valid/s_open_req_ready  in/out  1/1, plus s_open_rem_qpn  input  24  remote QPN of the open request.
REQ-006 SHALL have ports m_open_resp_valid/m_open_resp_ready  out/in  1/1, m_open_resp_qpn  output  24  allocated QPN, and m_open_resp_rem_qpn  output  24  echoed remote QPN.
REQ-007 SHALL have ports s_close_req_valid/s_close_req_ready  in/out  1/1, plus s_close_qpn  input  24  local QPN to free.
REQ-008 SHALL have ports m_close_resp_valid/m_close_resp_ready  out/in  1/1, m_close_resp_ok  output  1  close accepted, and m_close_resp_qpn  output  24  echoed QPN.
REQ-009 SHALL have ports s_qpn_fifo_valid/s_qpn_fifo_ready  in/out  1/1, plus s_qpn  input  24  head of the free-QPN list (pop side).
REQ-010 SHALL have ports m_qpn_fifo_valid/m_qpn_fifo_ready  out/in  1/1, plus m_qpn  output  24  QPN returned to the free list (push side).
REQ-011 SHALL have ports qp_active  output  MAX_QUEUE_PAIRS  per-QP allocated bitmap, and active_count  output  $clog2(MAX_QUEUE_PAIRS)+1  number of set bits.

Function
REQ-012 SHALL implement the FSM states IDLE, OPEN_RESP, CLOSE_CHECK, CLOSE_PUSH and CLOSE_RESP; any unused encoding SHALL return to IDLE.
REQ-013 SHALL, in IDLE, drive s_close_req_ready=1, and a close handshake SHALL capture s_close_qpn and go to CLOSE_CHECK.
REQ-014 SHALL, in IDLE, drive s_open_req_ready = s_qpn_fifo_valid && !s_close_req_valid, so that a close has priority over an open in the same cycle.
REQ-015 SHALL drive s_qpn_fifo_ready = s_open_req_valid && s_open_req_ready, a combinational pop in the same cycle as the open handshake.
REQ-016 SHALL, on an open handshake, capture s_qpn and s_open_rem_qpn, set qp_active[s_qpn-QPN_BASE], increment active_count, and go to OPEN_RESP.
REQ-017 SHALL, in OPEN_RESP, hold m_open_resp_valid=1 with stable data until m_open_resp_ready, then return to IDLE; the open-request-to-response latency is 1 cycle.
REQ-018 SHALL, in CLOSE_CHECK, judge the QPN valid when QPN_BASE <= qpn < QPN_BASE+MAX_QUEUE_PAIRS (full 24-bit compare) and its qp_active bit is set.
REQ-019 SHALL, for a valid QPN, clear the bit, decrement active_count and go to CLOSE_PUSH; otherwise it SHALL set ok=0 and go to CLOSE_RESP.
REQ-020 SHALL, in CLOSE_PUSH, hold m_qpn_fifo_valid=1 with m_qpn=captured QPN until m_qpn_fifo_ready, then set ok=1 and go to CLOSE_RESP.
REQ-021 SHALL, in CLOSE_RESP, hold m_close_resp_valid=1 with ok and qpn stable until m_close_resp_ready, then return to IDLE.
REQ-022 SHALL accept at most one request in flight; all s_*_ready outputs SHALL be 0 outside IDLE.
REQ-023 SHALL, when the free list is empty (s_qpn_fifo_valid=0), stall the open request with ready=0 and produce no response or error.
REQ-024 SHALL NOT change active_count on a double-close or an out-of-range close.
REQ-025 SHALL ensure active_count never wraps; a popped QPN that is out of range or already active SHALL still be returned in the response but SHALL NOT modify the bitmap.

Reset
REQ-026 SHALL, while rst_n=0, immediately force the state to IDLE, all valid and ready outputs to 0, qp_active=0, active_count=0, and data outputs to 0.
REQ-027 SHALL, on reset asserted mid-transaction, discard the transaction with no partial push and no response.
REQ-028 SHALL begin operation on the first rising clk edge after rst_n deasserts.

Verification
REQ-029 Open after reset with free list presenting 256, rem_qpn=0x000ABC -> response qpn=256, rem=0x000ABC one cycle later; qp_active=4'b0001, count=1.
REQ-030 Four opens (256..259) followed by a fifth open with s_qpn_fifo_valid=0 -> fifth open ready stays 0 for 20 cycles; count=4, no response.
REQ-031 Close 257 while active, m_qpn_fifo_ready held low for 3 cycles -> m_qpn_fifo_valid held with m_qpn=257; then resp ok=1, qpn=257, bit1 cleared, count decremented.
REQ-032 Close 258 while inactive, then close 300 -> each gives resp ok=0, no m_qpn_fifo_valid pulse, bitmap unchanged.
REQ-033 Open and close valid in the same IDLE cycle -> close accepted first, s_qpn_fifo_ready=0 that cycle, and open accepted only after the close response handshake.
REQ-034 Assert rst_n=0 during CLOSE_PUSH -> m_qpn_fifo_valid drops without a clock edge, qp_active=0, and the next cycle after release shows IDLE with close ready=1.
